// File: rtl/vcount_pkg.sv
// Shared constants for the vcount lab counter and its control stage.
// The default debounce and tick periods are derived from the board clock here.
package vcount_pkg;

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;
    localparam logic [CNT_W-1:0] CNT_MIN = 3'd0;

    localparam int CLK_HZ  = 50_000_000;
    localparam int DEB_HZ  = 1_000;
    localparam int TICK_HZ = 1;

    localparam int DEF_DEB_CYCLES = CLK_HZ / DEB_HZ;
    localparam int DEF_TICK_DIV   = CLK_HZ / TICK_HZ;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and press pulse.
// level follows din once din has held a new value for DEB_CYCLES cycles;
// press pulses for one cycle when level rises.
module btn_debounce
    import vcount_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == LAST);

    // Bring the raw button into the clock domain through two flops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Count consecutive cycles that disagree with the accepted level and flip it once long enough
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= accept && !level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (accept) begin
                cnt   <= '0;
                level <= ~level;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vcount_ctrl.sv
// Control stage in front of the 3-bit vcount counter: debounced buttons toggle
// pause/decrement, clear produces a one-cycle clr_n, and a divider makes tick.
// Optional macro VCOUNT_BOUNCE_EN: reverse direction automatically at 7 and 0 using q.
module vcount_ctrl
    import vcount_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int TICK_DIV   = DEF_TICK_DIV
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_dir,
    input  logic       btn_clr,
    input  logic [2:0] q,
    output logic       pause,
    output logic       decrement,
    output logic       tick,
    output logic       clr_n
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic          pause_press;
    logic          dir_press;
    logic          clr_press;
    logic          pause_level_unused;
    logic          dir_level_unused;
    logic          clr_level_unused;
    logic          pause_nxt;
    logic          dec_nxt;
    logic [DW-1:0] div;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_pause),
        .level (pause_level_unused),
        .press (pause_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dir (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_dir),
        .level (dir_level_unused),
        .press (dir_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_clr),
        .level (clr_level_unused),
        .press (clr_press)
    );

    assign pause_nxt = pause ^ pause_press;

`ifndef VCOUNT_BOUNCE_EN
    logic unused_q;
    assign unused_q = ^q;
`endif

    // Next direction: a Dir press always toggles; with bounce enabled the range ends turn the count round
    always_comb begin
        dec_nxt = decrement;
`ifdef VCOUNT_BOUNCE_EN
        if (dir_press) begin
            dec_nxt = ~decrement;
        end else if ((q == CNT_MAX) && !decrement) begin
            dec_nxt = 1'b1;
        end else if ((q == CNT_MIN) && decrement) begin
            dec_nxt = 1'b0;
        end
`else
        if (dir_press) begin
            dec_nxt = ~decrement;
        end
`endif
    end

    // Level outputs toggled by button presses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause     <= 1'b0;
            decrement <= 1'b0;
        end else begin
            pause     <= pause_nxt;
            decrement <= dec_nxt;
        end
    end

    // One-cycle active-low clear following a clear press
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_n <= 1'b1;
        end else begin
            clr_n <= ~clr_press;
        end
    end

    // Tick divider; frozen in any cycle where pause is set before or after the edge so tick never overlaps pause
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (clr_press) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (!pause && !pause_nxt) begin
            if (div == DIV_LAST) begin
                div  <= '0;
                tick <= 1'b1;
            end else begin
                div  <= div + DW'(1);
                tick <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vcount_ctrl.sv
// Self-checking bench for vcount_ctrl with DEB_CYCLES=4, TICK_DIV=5.
// A cycle-level behavioural model predicts all outputs; literal checks pin key timings.
module tb_vcount_ctrl;

    localparam int DEB = 4;
    localparam int TD  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_pause;
    logic       btn_dir;
    logic       btn_clr;
    logic [2:0] q;
    logic       pause;
    logic       decrement;
    logic       tick;
    logic       clr_n;

    int n_checks = 0;
    int n_fail   = 0;
    int ticks_seen = 0;
    bit chk_en = 1'b0;

    vcount_ctrl #(.DEB_CYCLES(DEB), .TICK_DIV(TD)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_pause (btn_pause),
        .btn_dir   (btn_dir),
        .btn_clr   (btn_clr),
        .q         (q),
        .pause     (pause),
        .decrement (decrement),
        .tick      (tick),
        .clr_n     (clr_n)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit         m_pause = 1'b0;
    bit         m_dec   = 1'b0;
    bit         m_tick  = 1'b0;
    bit         m_clrn  = 1'b1;
    int         m_phase = 0;
    bit         m_lvl   [3];
    int         m_run   [3];
    bit         m_press [3];
    logic [2:0] m_hist  [$];

    // Model: a button is accepted after DEB consecutive synchronised samples that differ from its level
    always @(posedge clk or negedge rst) begin : model
        logic [2:0] dly;
        bit         new_pause;
        bit         nxt_press [3];
        if (!rst) begin
            m_pause = 1'b0;
            m_dec   = 1'b0;
            m_tick  = 1'b0;
            m_clrn  = 1'b1;
            m_phase = 0;
            m_hist.delete();
            for (int i = 0; i < 3; i++) begin
                m_lvl[i]   = 1'b0;
                m_run[i]   = 0;
                m_press[i] = 1'b0;
            end
        end else begin
            new_pause = m_pause ^ m_press[0];
`ifdef VCOUNT_BOUNCE_EN
            if (m_press[1])               m_dec = !m_dec;
            else if (q == 3'd7 && !m_dec) m_dec = 1'b1;
            else if (q == 3'd0 && m_dec)  m_dec = 1'b0;
`else
            if (m_press[1]) m_dec = !m_dec;
`endif
            m_clrn = !m_press[2];
            if (m_press[2]) begin
                m_phase = 0;
                m_tick  = 1'b0;
            end else if (!m_pause && !new_pause) begin
                m_phase = m_phase + 1;
                m_tick  = (m_phase == TD);
                if (m_phase == TD) m_phase = 0;
            end else begin
                m_tick = 1'b0;
            end
            m_pause = new_pause;

            m_hist.push_front({btn_clr, btn_dir, btn_pause});
            if (m_hist.size() > 3) void'(m_hist.pop_back());
            dly = (m_hist.size() == 3) ? m_hist[2] : 3'b000;
            for (int i = 0; i < 3; i++) begin
                nxt_press[i] = 1'b0;
                if (dly[i] != m_lvl[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        nxt_press[i] = !m_lvl[i];
                        m_lvl[i]     = !m_lvl[i];
                        m_run[i]     = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_press[i] = nxt_press[i];
            end
        end
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %b, required %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("model_pause", pause, m_pause);
            checkOutput("model_decrement", decrement, m_dec);
            checkOutput("model_tick", tick, m_tick);
            checkOutput("model_clr_n", clr_n, m_clrn);
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            if (tick) ticks_seen++;
        end
    endtask

    task automatic applyStimulus(input logic p, input logic d, input logic c);
        btn_pause = p;
        btn_dir   = d;
        btn_clr   = c;
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_pause"}, pause, 1'b0);
        checkOutput({tag, "_decrement"}, decrement, 1'b0);
        checkOutput({tag, "_tick"}, tick, 1'b0);
        checkOutput({tag, "_clr_n"}, clr_n, 1'b1);
    endtask

    task automatic reset_mid_run();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_values("midrun_reset");
        wait_cycles(2);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        q = 3'd3;
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        check_reset_values("reset");
        wait_cycles(3);
        rst = 1'b1;

        // first tick five cycles after reset release
        wait_cycles(4);
        checkOutput("tick_before_first", tick, 1'b0);
        wait_cycles(1);
        checkOutput("tick_first", tick, 1'b1);

        // three-cycle glitch is ignored
        wait_cycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);
        checkOutput("glitch_no_pause", pause, 1'b0);

        // long press: pause rises exactly seven cycles after the input
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(6);
        checkOutput("press_pause_at6", pause, 1'b0);
        wait_cycles(1);
        checkOutput("press_pause_at7", pause, 1'b1);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks_seen = 0;
        wait_cycles(12);
        checkOutput("release_keeps_pause", pause, 1'b1);
        checkValue("ticks_while_paused", ticks_seen, 0);

        // pause with the divider at 2, then resume from the held value
        reset_mid_run();
        wait_cycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(6);
        checkOutput("hold_pause_at6", pause, 1'b0);
        wait_cycles(1);
        checkOutput("hold_pause_at7", pause, 1'b1);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ticks_seen = 0;
        wait_cycles(20);
        checkValue("hold_no_ticks", ticks_seen, 0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(7);
        checkOutput("unpause", pause, 1'b0);
        checkOutput("unpause_tick", tick, 1'b0);
        wait_cycles(2);
        checkOutput("resume_tick_early", tick, 1'b0);
        wait_cycles(1);
        checkOutput("resume_tick", tick, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // pause and dir pressed together toggle on the same edge
        wait_cycles(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        wait_cycles(6);
        checkOutput("simul_pause_at6", pause, 1'b0);
        checkOutput("simul_dec_at6", decrement, 1'b0);
        wait_cycles(1);
        checkOutput("simul_pause_at7", pause, 1'b1);
        checkOutput("simul_dec_at7", decrement, 1'b1);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);
        applyStimulus(1'b1, 1'b0, 1'b0);
        wait_cycles(7);
        checkOutput("simul_unpause", pause, 1'b0);
        wait_cycles(3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);

        // clear: one-cycle clr_n, divider restarts
        applyStimulus(1'b0, 1'b0, 1'b1);
        wait_cycles(6);
        checkOutput("clr_n_before", clr_n, 1'b1);
        wait_cycles(1);
        checkOutput("clr_n_low", clr_n, 1'b0);
        checkOutput("clr_tick", tick, 1'b0);
        wait_cycles(1);
        checkOutput("clr_n_high_again", clr_n, 1'b1);
        wait_cycles(3);
        checkOutput("clr_tick_early", tick, 1'b0);
        wait_cycles(1);
        checkOutput("clr_tick_restart", tick, 1'b1);
        checkOutput("clr_keeps_dec", decrement, 1'b1);
        checkOutput("clr_keeps_pause", pause, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);

        // range ends: bounce reverses, otherwise direction is left alone
        reset_mid_run();
        wait_cycles(2);
        q = 3'd6;
        wait_cycles(1);
        q = 3'd7;
        wait_cycles(1);
`ifdef VCOUNT_BOUNCE_EN
        checkOutput("bounce_top", decrement, 1'b1);
`else
        checkOutput("wrap_top", decrement, 1'b0);
`endif
        q = 3'd0;
        wait_cycles(1);
        checkOutput("bottom_dec", decrement, 1'b0);
        q = 3'd3;
        wait_cycles(3);

        // dir press on its own
        applyStimulus(1'b0, 1'b1, 1'b0);
        wait_cycles(7);
        checkOutput("dir_toggle", decrement, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        wait_cycles(10);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
